// File: rtl/key_debounce_multi.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce_multi
// Brief    : N-channel push-button conditioner: 2-flop sync, saturating
//            stability counter, debounced level and press/release pulses.
//            Optional auto-repeat via macro KEYCHK_AUTO_REPEAT_EN.
//            The release pulse port is key_release ("release" is reserved).
// Revision : 1.0 - initial release
// ============================================================================
module key_debounce_multi #(
  parameter int N_KEYS        = 4,
  parameter int DEBOUNCE_CYC  = 1000,
  parameter int CNT_W         = 21,
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000,
  parameter int RPT_W         = 25
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key,
  output logic [N_KEYS-1:0] key_v,
  output logic [N_KEYS-1:0] press,
  output logic [N_KEYS-1:0] key_release
);

  localparam logic [CNT_W-1:0] c_DB_MAX = CNT_W'(DEBOUNCE_CYC - 1);

  if ((N_KEYS < 1) || (N_KEYS > 16) || (DEBOUNCE_CYC < 2) ||
      ((64'd1 << CNT_W) <= 64'(DEBOUNCE_CYC)) ||
      (REPEAT_DELAY < 2) || (REPEAT_PERIOD < 2) ||
      ((64'd1 << RPT_W) <= 64'(REPEAT_DELAY)) ||
      ((64'd1 << RPT_W) <= 64'(REPEAT_PERIOD))) begin : g_cfg_err
    $error("key_debounce_multi: illegal parameter combination");
  end

  genvar i;
  for (i = 0; i < N_KEYS; i++) begin : g_key
    logic             r_s1, r_s2, r_s3;
    logic [CNT_W-1:0] r_cnt;
    logic             r_kv, r_press, r_rel;
    logic             w_chg, w_acc;

    assign w_chg = r_s2 ^ r_s3;
    // Accept only a level that has survived the full stability window.
    assign w_acc = ~w_chg & (r_cnt == c_DB_MAX) & (r_s2 != r_kv);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_s1  <= 1'b0;
        r_s2  <= 1'b0;
        r_s3  <= 1'b0;
        r_cnt <= '0;
        r_kv  <= 1'b0;
        r_rel <= 1'b0;
      end else begin
        r_s1 <= key[i];
        r_s2 <= r_s1;
        r_s3 <= r_s2;
        if (w_chg) begin
          r_cnt <= '0;
        end else if (r_cnt != c_DB_MAX) begin
          r_cnt <= r_cnt + 1'b1;
        end
        if (w_acc) begin
          r_kv <= r_s2;
        end
        r_rel <= w_acc & ~r_s2;
      end
    end

`ifdef KEYCHK_AUTO_REPEAT_EN
    localparam logic [RPT_W-1:0] c_RPT_FIRST   = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] c_RPT_NEXT    = RPT_W'(REPEAT_PERIOD - 1);
    localparam logic [0:0]       c_PH_DELAY    = 1'b0;
    localparam logic [0:0]       c_PH_PERIODIC = 1'b1;

    logic [RPT_W-1:0] r_rc;
    logic [0:0]       r_phase;
    logic [RPT_W-1:0] w_rpt_limit;

    assign w_rpt_limit = (r_phase == c_PH_PERIODIC) ? c_RPT_NEXT : c_RPT_FIRST;

    // Any acceptance (press or release) or a released key restarts the delay phase.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_rc    <= '0;
        r_phase <= c_PH_DELAY;
        r_press <= 1'b0;
      end else if (w_acc || !r_kv) begin
        r_rc    <= '0;
        r_phase <= c_PH_DELAY;
        r_press <= w_acc & r_s2;
      end else if (r_rc == w_rpt_limit) begin
        r_rc    <= '0;
        r_phase <= c_PH_PERIODIC;
        r_press <= 1'b1;
      end else begin
        r_rc    <= r_rc + 1'b1;
        r_press <= 1'b0;
      end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_press <= 1'b0;
      end else begin
        r_press <= w_acc & r_s2;
      end
    end
`endif

    assign key_v[i]       = r_kv;
    assign press[i]       = r_press;
    assign key_release[i] = r_rel;
  end

endmodule
`default_nettype wire
